// File: rtl/dcache_fill_ctrl.sv
// Data-cache line fill controller: on a miss, reads the victim's dirty state,
// writes back dirty victim beats one at a time, bursts the new line in from
// DRAM, assembles it beat by beat and writes it into the dcache.
module dcache_fill_ctrl #(
    parameter int LOG2DCACHEWIDTHBITS = 7,
    parameter int LOG2DRAMWIDTHBITS   = 5
) (
    input  logic                                mem_clk,
    input  logic                                resetn,
    input  logic                                req_valid,
    input  logic [31:0]                         req_addr,
    output logic                                req_ready,
    output logic                                req_done,
    output logic [31:0]                         dmem_filladdr,
    output logic [(2**LOG2DCACHEWIDTHBITS)-1:0] dmem_filldata,
    output logic                                dmem_fillwe,
    output logic                                dmem_fillrddirty,
    input  logic [31:0]                         dmem_wbaddr,
    input  logic [(2**LOG2DRAMWIDTHBITS)-1:0]   dmem_wbdata,
    input  logic                                dmem_wbwe,
    output logic                                dmem_wback,
    output logic [31:0]                         dram_addr,
    output logic                                dram_rd,
    output logic                                dram_wr,
    output logic [(2**LOG2DRAMWIDTHBITS)-1:0]   dram_wdata,
    input  logic                                dram_ready,
    input  logic [(2**LOG2DRAMWIDTHBITS)-1:0]   dram_rdata,
    input  logic                                dram_rdvalid
);

    localparam int L     = 2 ** LOG2DCACHEWIDTHBITS;
    localparam int W     = 2 ** LOG2DRAMWIDTHBITS;
    localparam int BEATS = L / W;
    // One extra bit so the counter can hold BEATS itself instead of wrapping.
    localparam int CW    = LOG2DCACHEWIDTHBITS - LOG2DRAMWIDTHBITS + 1;
    localparam int OFS   = LOG2DCACHEWIDTHBITS - 3;
    localparam logic [CW-1:0] BEATS_C   = CW'(BEATS);
    localparam logic [31:0]   LINE_MASK = ~((32'd1 << OFS) - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VICTIM,
        S_WBCHK,
        S_WB,
        S_RDCMD,
        S_RDDATA,
        S_FILL
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  cnt_inc;
    logic [31:0]    base_q, base_d;
    logic [L-1:0]   line_q, line_d;
    logic [BEATS-1:0] beat_we;

    assign cnt_inc       = cnt_q + CW'(1);
    assign dmem_filladdr = base_q;
    assign dmem_filldata = line_q;

    // Each line slot captures the read beat whose index matches the counter.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
            assign beat_we[gi] = (state_q == S_RDDATA) && dram_rdvalid && (cnt_q == CW'(gi));
            assign line_d[gi*W +: W] = beat_we[gi] ? dram_rdata : line_q[gi*W +: W];
        end
    endgenerate

    // Next-state, beat counter and command/strobe outputs for the fill sequence.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        base_d           = base_q;
        req_ready        = 1'b0;
        req_done         = 1'b0;
        dmem_fillwe      = 1'b0;
        dmem_fillrddirty = 1'b0;
        dmem_wback       = 1'b0;
        dram_rd          = 1'b0;
        dram_wr          = 1'b0;
        dram_addr        = base_q;
        dram_wdata       = dmem_wbdata;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    base_d  = req_addr & LINE_MASK;
                    state_d = S_VICTIM;
                end
            end
            S_VICTIM: begin
                dmem_fillrddirty = 1'b1;
                state_d          = S_WBCHK;
            end
            S_WBCHK: begin
                state_d = dmem_wbwe ? S_WB : S_RDCMD;
            end
            S_WB: begin
                // The write command is presented as soon as the dcache offers a
                // beat and is held until DRAM takes it.
                dram_wr   = dmem_wbwe;
                dram_addr = dmem_wbaddr;
                if (dmem_wbwe && dram_ready) begin
                    dmem_wback = 1'b1;
                    if (cnt_inc == BEATS_C) begin
                        cnt_d   = '0;
                        state_d = S_RDCMD;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_RDCMD: begin
                dram_rd = 1'b1;
                if (dram_ready) begin
                    state_d = S_RDDATA;
                end
            end
            S_RDDATA: begin
                if (dram_rdvalid) begin
                    if (cnt_inc == BEATS_C) begin
                        cnt_d   = '0;
                        state_d = S_FILL;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_FILL: begin
                dmem_fillwe = 1'b1;
                req_done    = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state and beat counter; reset abandons any transfer in flight.
    always_ff @(posedge mem_clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Line address and assembled line; their contents after reset do not matter.
    always_ff @(posedge mem_clk) begin
        base_q <= base_d;
        line_q <= line_d;
    end

endmodule

// File: tb/tb_dcache_fill_ctrl.sv
// Randomized bench for dcache_fill_ctrl: the bench plays dcache and DRAM and
// tracks each miss as a transaction (victim beats left, read burst progress,
// expected line) to predict the outputs on every cycle.
module tb_dcache_fill_ctrl;

    localparam int L      = 128;
    localparam int W      = 32;
    localparam int BEATS  = 4;
    localparam int NREQ   = 46;
    localparam int MAXCYC = 20000;

    logic            mem_clk = 1'b0;
    logic            resetn;
    logic            req_valid;
    logic [31:0]     req_addr;
    logic            req_ready;
    logic            req_done;
    logic [31:0]     dmem_filladdr;
    logic [L-1:0]    dmem_filldata;
    logic            dmem_fillwe;
    logic            dmem_fillrddirty;
    logic [31:0]     dmem_wbaddr;
    logic [W-1:0]    dmem_wbdata;
    logic            dmem_wbwe;
    logic            dmem_wback;
    logic [31:0]     dram_addr;
    logic            dram_rd;
    logic            dram_wr;
    logic [W-1:0]    dram_wdata;
    logic            dram_ready;
    logic [W-1:0]    dram_rdata;
    logic            dram_rdvalid;

    always #5 mem_clk = ~mem_clk;

    dcache_fill_ctrl dut (
        .mem_clk          (mem_clk),
        .resetn           (resetn),
        .req_valid        (req_valid),
        .req_addr         (req_addr),
        .req_ready        (req_ready),
        .req_done         (req_done),
        .dmem_filladdr    (dmem_filladdr),
        .dmem_filldata    (dmem_filldata),
        .dmem_fillwe      (dmem_fillwe),
        .dmem_fillrddirty (dmem_fillrddirty),
        .dmem_wbaddr      (dmem_wbaddr),
        .dmem_wbdata      (dmem_wbdata),
        .dmem_wbwe        (dmem_wbwe),
        .dmem_wback       (dmem_wback),
        .dram_addr        (dram_addr),
        .dram_rd          (dram_rd),
        .dram_wr          (dram_wr),
        .dram_wdata       (dram_wdata),
        .dram_ready       (dram_ready),
        .dram_rdata       (dram_rdata),
        .dram_rdvalid     (dram_rdvalid)
    );

    int vectors     = 0;
    int miscompares = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Scenario table: ready mode 0=always 1=random 2=stall 3 cycles per phase;
    // data mode 0=every cycle 1=every other cycle 2=random; rst = beat count at
    // which reset hits the read burst (-1 = none).
    logic [31:0] sc_addr  [NREQ];
    bit          sc_dirty [NREQ];
    int          sc_rmode [NREQ];
    int          sc_dmode [NREQ];
    int          sc_rst   [NREQ];
    bit          sc_fixed [NREQ];

    // Transaction-level model of the miss in progress.
    bit          busy, wb_phase, rd_cmd, rd_data, fill_pend, rd_tog;
    int          cyc, wb_done, rd_got, stall, gap, req_idx, cycles, wr_seen, rd_seen;
    logic [31:0] m_base;
    logic [L-1:0] m_line;
    logic [W-1:0] vic [BEATS];

    initial begin
        sc_addr[0] = 32'h00001234; sc_dirty[0] = 0; sc_rmode[0] = 0; sc_dmode[0] = 0; sc_rst[0] = -1; sc_fixed[0] = 1;
        sc_addr[1] = 32'h00005000; sc_dirty[1] = 1; sc_rmode[1] = 0; sc_dmode[1] = 0; sc_rst[1] = -1; sc_fixed[1] = 0;
        sc_addr[2] = 32'h00007788; sc_dirty[2] = 1; sc_rmode[2] = 2; sc_dmode[2] = 0; sc_rst[2] = -1; sc_fixed[2] = 0;
        sc_addr[3] = 32'h00009abc; sc_dirty[3] = 0; sc_rmode[3] = 0; sc_dmode[3] = 1; sc_rst[3] = -1; sc_fixed[3] = 1;
        sc_addr[4] = 32'h00002468; sc_dirty[4] = 1; sc_rmode[4] = 1; sc_dmode[4] = 0; sc_rst[4] = 2;  sc_fixed[4] = 0;
        sc_addr[5] = 32'h00001357; sc_dirty[5] = 0; sc_rmode[5] = 0; sc_dmode[5] = 0; sc_rst[5] = -1; sc_fixed[5] = 0;
        for (int i = 6; i < NREQ; i++) begin
            sc_addr[i]  = $urandom;
            sc_dirty[i] = 1'($urandom_range(0, 1));
            sc_rmode[i] = int'($urandom_range(0, 2));
            sc_dmode[i] = int'($urandom_range(0, 2));
            sc_rst[i]   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            sc_fixed[i] = 0;
        end

        busy = 0; wb_phase = 0; rd_cmd = 0; rd_data = 0; fill_pend = 0; rd_tog = 0;
        cyc = 0; wb_done = 0; rd_got = 0; stall = 0; gap = 0; req_idx = 0; cycles = 0;
        wr_seen = 0; rd_seen = 0; m_base = '0; m_line = '0;

        resetn = 1'b0; req_valid = 1'b0; req_addr = '0; dmem_wbaddr = '0; dmem_wbdata = '0;
        dmem_wbwe = 1'b0; dram_ready = 1'b0; dram_rdata = '0; dram_rdvalid = 1'b0;
        repeat (3) @(negedge mem_clk);

        while (req_idx < NREQ && cycles < MAXCYC) begin
            @(negedge mem_clk);
            cycles++;

            // ---- drive: the bench acts as dcache and DRAM ----
            resetn       = 1'b1;
            req_valid    = 1'b0;
            req_addr     = $urandom;
            dmem_wbwe    = 1'b0;
            dmem_wbaddr  = $urandom;
            dmem_wbdata  = $urandom;
            dram_ready   = ($urandom_range(0, 3) != 0);
            dram_rdvalid = 1'b0;
            dram_rdata   = $urandom;
            if (!busy) begin
                if (gap == 0) begin
                    req_valid = 1'b1;
                    req_addr  = sc_addr[req_idx];
                end else begin
                    gap--;
                end
                dram_rdvalid = ($urandom_range(0, 2) == 0);
                dmem_wbwe    = ($urandom_range(0, 2) == 0);
            end else begin
                req_valid = ($urandom_range(0, 3) == 0);
                if (cyc == 1 || rd_cmd || rd_data || fill_pend)
                    dmem_wbwe = ($urandom_range(0, 2) == 0);
                if (cyc == 2) begin
                    dmem_wbwe   = sc_dirty[req_idx];
                    dmem_wbaddr = m_base;
                    dmem_wbdata = vic[0];
                end
                if (wb_phase) begin
                    dmem_wbwe   = (sc_rmode[req_idx] == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
                    dmem_wbaddr = m_base + 32'(4 * wb_done);
                    dmem_wbdata = vic[wb_done];
                end
                if (sc_rmode[req_idx] == 0) begin
                    dram_ready = 1'b1;
                end else if (sc_rmode[req_idx] == 2) begin
                    dram_ready = 1'b1;
                    if ((wb_phase || rd_cmd) && stall > 0) begin
                        dram_ready = 1'b0;
                        stall--;
                    end
                end
                if (!rd_data) begin
                    dram_rdvalid = ($urandom_range(0, 2) == 0);
                end else begin
                    if (sc_dmode[req_idx] == 0) begin
                        dram_rdvalid = 1'b1;
                    end else if (sc_dmode[req_idx] == 1) begin
                        dram_rdvalid = rd_tog;
                        rd_tog = !rd_tog;
                    end else begin
                        dram_rdvalid = 1'($urandom_range(0, 1));
                    end
                    if (sc_fixed[req_idx]) dram_rdata = 32'h11 * 32'(rd_got + 1);
                    if (rd_got == sc_rst[req_idx]) begin
                        resetn    = 1'b0;
                        req_valid = 1'b0;
                    end
                end
            end
            #1;

            // ---- compare against the model ----
            if (resetn) begin
                chk("req_ready", req_ready, !busy);
                chk("fillrddirty", dmem_fillrddirty, busy && cyc == 1);
                chk("dram_wr", dram_wr, wb_phase && dmem_wbwe);
                chk("dmem_wback", dmem_wback, wb_phase && dmem_wbwe && dram_ready);
                chk("dram_rd", dram_rd, rd_cmd);
                chk("fillwe", dmem_fillwe, fill_pend);
                chk("req_done", req_done, fill_pend);
                if (busy) chk("filladdr", dmem_filladdr, m_base);
                if (busy && cyc == 1 && req_idx == 0) chk("lit_victim_addr", dmem_filladdr, 32'h00001230);
                if (wb_phase && dmem_wbwe) begin
                    chk("wr_addr", dram_addr, dmem_wbaddr);
                    chk("wr_data", dram_wdata, dmem_wbdata);
                end
                if (wb_phase && dmem_wbwe && dram_ready && req_idx == 1)
                    chk("lit_wr_addr", dram_addr, 32'h00005000 + 32'(4 * wb_done));
                if (rd_cmd) chk("rd_addr", dram_addr, m_base);
                if (rd_cmd && req_idx == 0) chk("lit_rd_addr", dram_addr, 32'h00001230);
                if (dram_wr && dram_ready) wr_seen++;
                if (dram_rd && dram_ready) rd_seen++;
                if (fill_pend) begin
                    chk("filldata", dmem_filldata, m_line);
                    chk("wr_count", wr_seen, sc_dirty[req_idx] ? BEATS : 0);
                    chk("rd_count", rd_seen, 1);
                    if (req_idx == 0)
                        chk("lit_filldata", dmem_filldata, 128'h00000044_00000033_00000022_00000011);
                end
            end

            // ---- advance the model by what this cycle accomplished ----
            if (!resetn) begin
                $display("req %0d addr=%h aborted by reset after %0d read beats", req_idx, sc_addr[req_idx], rd_got);
                busy = 0; wb_phase = 0; rd_cmd = 0; rd_data = 0; fill_pend = 0;
                req_idx++;
                gap = int'($urandom_range(0, 2));
            end else if (!busy) begin
                if (req_valid) begin
                    busy    = 1;
                    cyc     = 1;
                    m_base  = req_addr - (req_addr % 32'd16);
                    m_line  = '0;
                    wr_seen = 0;
                    rd_seen = 0;
                    for (int k = 0; k < BEATS; k++) vic[k] = $urandom;
                end
            end else begin
                if (fill_pend) begin
                    $display("req %0d addr=%h base=%h dirty=%0d writes=%0d line=%h", req_idx,
                             sc_addr[req_idx], m_base, sc_dirty[req_idx], wr_seen, m_line);
                    fill_pend = 0;
                    busy      = 0;
                    req_idx++;
                    gap = int'($urandom_range(0, 2));
                end else if (rd_data) begin
                    if (dram_rdvalid) begin
                        m_line[rd_got*W +: W] = dram_rdata;
                        rd_got++;
                        if (rd_got == BEATS) begin
                            rd_data   = 0;
                            fill_pend = 1;
                        end
                    end
                end else if (rd_cmd) begin
                    if (dram_ready) begin
                        rd_cmd  = 0;
                        rd_data = 1;
                        rd_got  = 0;
                        rd_tog  = 0;
                    end
                end else if (wb_phase) begin
                    if (dmem_wbwe && dram_ready) begin
                        wb_done++;
                        if (wb_done == BEATS) begin
                            wb_phase = 0;
                            rd_cmd   = 1;
                            stall    = 3;
                        end
                    end
                end else if (cyc == 2) begin
                    if (dmem_wbwe) begin
                        wb_phase = 1;
                        wb_done  = 0;
                    end else begin
                        rd_cmd = 1;
                    end
                    stall = 3;
                end
                cyc++;
            end
        end

        if (req_idx < NREQ) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: completed %0d requests, required %0d", req_idx, NREQ);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
